// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with req/ack handshake and fixed access latency.
// Optional macro DMEM_ALIGN_CHECK_EN: reject misaligned halfword/word accesses with err_o.
module data_memory_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] WrData_i,
  input  logic        MemWr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] RdData_o,
  output logic        err_o
);

  localparam int BANK_WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                wr_q, wr_d;
  logic                uns_q, uns_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                do_access;
  logic                misalign;
  logic                acc_err;
  logic [2:0]          nbytes;
  logic [7:0]          bank_rd [4];
  logic [7:0]          ld_bytes [4];
  logic [31:0]         ld_value;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^addr_i[31:ADDR_W];

  assign do_access = (state_q == S_WAIT) && (cnt_q == 8'd0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = (size_q == 2'b11) || misalign;

  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  // Four byte-wide banks indexed by address[1:0]; a lane whose byte falls
  // before the start lane belongs to the next word, which gives wrap-around.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [7:0]        bank_mem [BANK_WORDS];
    logic [1:0]        off;
    logic              carry;
    logic [ADDR_W-3:0] widx;
    logic              we;
    logic [7:0]        wbyte;

    always_comb begin
      off   = 2'(gi) - addr_q[1:0];
      carry = (2'(gi) < addr_q[1:0]);
      widx  = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(carry);
      we    = rst_i && do_access && wr_q && !acc_err && ({1'b0, off} < nbytes);
      wbyte = 8'(wdata_q >> {off, 3'b000});
    end

    always_ff @(posedge clk_i) begin
      if (we) begin
        bank_mem[widx] <= wbyte;
      end
    end

    assign bank_rd[gi] = bank_mem[widx];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ld_bytes[i] = bank_rd[2'(addr_q[1:0] + 2'(i))];
    end
    case (size_q)
      2'b00:   ld_value = {{24{~uns_q & ld_bytes[0][7]}}, ld_bytes[0]};
      2'b01:   ld_value = {{16{~uns_q & ld_bytes[1][7]}}, ld_bytes[1], ld_bytes[0]};
      default: ld_value = {ld_bytes[3], ld_bytes[2], ld_bytes[1], ld_bytes[0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    wr_d    = wr_q;
    uns_d   = uns_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i[ADDR_W-1:0];
          wdata_d = WrData_i;
          size_d  = size_i;
          wr_d    = MemWr_i;
          uns_d   = unsigned_i;
          cnt_d   = 8'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          ack_d   = 1'b1;
          err_d   = acc_err;
          state_d = S_RESP;
          if (!wr_q) begin
            rdata_d = acc_err ? 32'd0 : ld_value;
          end
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      uns_q   <= uns_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o   = busy_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign RdData_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (ADDR_W=10, LATENCY=4) with hand-computed expectations.
module tb_data_memory_ctrl;
  localparam int LAT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] WrData_i = 32'd0;
  logic        MemWr_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic        busy_o, ack_o, err_o;
  logic [31:0] RdData_o;

  int errors = 0;
  int checks = 0;

  data_memory_ctrl #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
    .WrData_i(WrData_i), .MemWr_i(MemWr_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .busy_o(busy_o), .ack_o(ack_o),
    .RdData_o(RdData_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic mem_access(input string tag, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er);
    int n;
    logic busy_ok;
    @(negedge clk_i);
    req_i = 1'b1; MemWr_i = wr; size_i = sz; unsigned_i = uns; addr_i = a; WrData_i = d;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    busy_ok = busy_o;
    n = 0;
    while (ack_o !== 1'b1 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
      busy_ok = busy_ok & busy_o;
    end
    check_value({tag, " latency"}, 32'(n), 32'(LAT));
    check_value({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    rd = RdData_o;
    er = err_o;
    @(posedge clk_i); #1;
    check_value({tag, " idle"}, {29'd0, busy_o, ack_o, err_o}, 32'd0);
    $display("txn %s wr=%0d size=%0d addr=0x%03h wdata=0x%08h rd=0x%08h err=%0d lat=%0d",
             tag, wr, sz, a, d, rd, er, n);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    int t[3];
    int nack;
    int cyc;

    // Reset
    repeat (3) @(posedge clk_i);
    #1;
    check_value("reset ctl", {29'd0, busy_o, ack_o, err_o}, 32'd0);
    check_value("reset rd", RdData_o, 32'd0);
    rst_i = 1'b1;

    // 1: word store / loads
    mem_access("t1 st w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    check_value("t1 st rd held", rd, 32'd0);
    check_value("t1 st err", {31'd0, er}, 32'd0);
    mem_access("t1 ld w", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er);
    check_value("t1 ld w", rd, 32'hDEADBEEF);
    mem_access("t1 ld b10", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, rd, er);
    check_value("t1 ld b10", rd, 32'hFFFFFFEF);
    mem_access("t1 ld b13", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, rd, er);
    check_value("t1 ld b13", rd, 32'hFFFFFFDE);

    // 2: halfword store / loads
    mem_access("t2 st w", 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, rd, er);
    check_value("t2 st rd held", rd, 32'hFFFFFFDE);
    mem_access("t2 st h", 1'b1, 2'b01, 1'b0, 32'h20, 32'hAAAA8001, rd, er);
    mem_access("t2 ld hs", 1'b0, 2'b01, 1'b0, 32'h20, 32'd0, rd, er);
    check_value("t2 ld hs", rd, 32'hFFFF8001);
    mem_access("t2 ld hu", 1'b0, 2'b01, 1'b1, 32'h20, 32'd0, rd, er);
    check_value("t2 ld hu", rd, 32'h00008001);
    mem_access("t2 ld b22", 1'b0, 2'b00, 1'b1, 32'h22, 32'd0, rd, er);
    check_value("t2 ld b22", rd, 32'h00000034);

    // 3a: req held high -> one access per LAT+2 cycles
    @(negedge clk_i);
    req_i = 1'b1; MemWr_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h10;
    nack = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) begin
        if (nack < 3) t[nack] = c;
        nack++;
      end
    end
    req_i = 1'b0;
    check_value("t3 ack count", 32'(nack), 32'd5);
    check_value("t3 first ack", 32'(t[0]), 32'(1 + LAT));
    check_value("t3 period a", 32'(t[1] - t[0]), 32'(LAT + 2));
    check_value("t3 period b", 32'(t[2] - t[1]), 32'(LAT + 2));
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check_value("t3 drained", {31'd0, busy_o}, 32'd0);

    // 3b: extra req pulse during WAIT is ignored
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h10;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(posedge clk_i); #1;
    req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    nack = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) nack++;
    end
    check_value("t3 pulse acks", 32'(nack), 32'd1);
    $display("txn t3 held-req and wait-pulse acks=%0d", nack);

    // 4: reset on the commit edge of a store
    mem_access("t4 st w", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEBABE, rd, er);
    mem_access("t4 ld w", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, er);
    check_value("t4 ld pre", rd, 32'hCAFEBABE);
    @(negedge clk_i);
    req_i = 1'b1; MemWr_i = 1'b1; size_i = 2'b10; addr_i = 32'h40; WrData_i = 32'h11111111;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (LAT - 1) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_value("t4 rst ctl", {29'd0, busy_o, ack_o, err_o}, 32'd0);
    check_value("t4 rst rd", RdData_o, 32'd0);
    rst_i = 1'b1;
    nack = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) nack++;
    end
    check_value("t4 no ack", 32'(nack), 32'd0);
    $display("txn t4 reset during store, acks after=%0d", nack);
    mem_access("t4 ld post", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, er);
    check_value("t4 ld post", rd, 32'hCAFEBABE);

`ifndef DMEM_ALIGN_CHECK_EN
    // 5: wrap-around at top of memory
    mem_access("t5 st w", 1'b1, 2'b10, 1'b0, 32'h3FE, 32'h11223344, rd, er);
    check_value("t5 st err", {31'd0, er}, 32'd0);
    mem_access("t5 b3fe", 1'b0, 2'b00, 1'b1, 32'h3FE, 32'd0, rd, er);
    check_value("t5 b3fe", rd, 32'h44);
    mem_access("t5 b3ff", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'd0, rd, er);
    check_value("t5 b3ff", rd, 32'h33);
    mem_access("t5 b000", 1'b0, 2'b00, 1'b1, 32'h000, 32'd0, rd, er);
    check_value("t5 b000", rd, 32'h22);
    mem_access("t5 b001", 1'b0, 2'b00, 1'b1, 32'h001, 32'd0, rd, er);
    check_value("t5 b001", rd, 32'h11);
    mem_access("t5 w3fe", 1'b0, 2'b10, 1'b0, 32'h3FE, 32'd0, rd, er);
    check_value("t5 w3fe", rd, 32'h11223344);
`endif

    // 6: reserved size
    mem_access("t6 ld w", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er);
    check_value("t6 ld w", rd, 32'hDEADBEEF);
    mem_access("t6 st rsv", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, rd, er);
    check_value("t6 st rsv err", {31'd0, er}, 32'd1);
    check_value("t6 st rsv rd", rd, 32'hDEADBEEF);
    mem_access("t6 ld rsv", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, rd, er);
    check_value("t6 ld rsv err", {31'd0, er}, 32'd1);
    check_value("t6 ld rsv rd", rd, 32'd0);
    mem_access("t6 ld w2", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er);
    check_value("t6 mem kept", rd, 32'hDEADBEEF);

`ifdef DMEM_ALIGN_CHECK_EN
    mem_access("t6 st w0", 1'b1, 2'b10, 1'b0, 32'h00, 32'h01020304, rd, er);
    check_value("t6 st w0 err", {31'd0, er}, 32'd0);
    mem_access("t6 st mis", 1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFFFFFF, rd, er);
    check_value("t6 st mis err", {31'd0, er}, 32'd1);
    mem_access("t6 ld w0", 1'b0, 2'b10, 1'b0, 32'h00, 32'd0, rd, er);
    check_value("t6 ld w0", rd, 32'h01020304);
    mem_access("t6 ld mis", 1'b0, 2'b01, 1'b0, 32'h01, 32'd0, rd, er);
    check_value("t6 ld mis err", {31'd0, er}, 32'd1);
    check_value("t6 ld mis rd", rd, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
